// File: rtl/sif_wbridge_if.sv
`timescale 1ns/1ps
// Bus bundle for sif_wbridge: X-side register access plus the W-side
// valid/ready forwarding port. The slave modport is the bridge's view.
interface sif_wbridge_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] xa_addr;
  logic [DATA_W-1:0] xa_data_wr;
  logic              xa_wr_s;
  logic              xa_rd_s;
  logic [DATA_W-1:0] xa_data_rd;
  logic              xa_rd_vld;
  logic              xa_err;
  logic              xa_busy;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data_wr;
  logic              wa_wr_s;
  logic              wa_rdy;
  logic [LVL_W-1:0]  wa_level;
  logic [CNT_W-1:0]  drop_cnt;

  modport slave (
    input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_rdy,
    output xa_data_rd, xa_rd_vld, xa_err, xa_busy,
           wa_addr, wa_data_wr, wa_wr_s, wa_level, drop_cnt
  );

  modport master (
    output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_rdy,
    input  xa_data_rd, xa_rd_vld, xa_err, xa_busy,
           wa_addr, wa_data_wr, wa_wr_s, wa_level, drop_cnt
  );
endinterface

// File: rtl/sif_wbridge.sv
`timescale 1ns/1ps
// Register-file slave whose accepted X-side writes are queued in a show-ahead
// FIFO and replayed in order on a valid/ready W side.
module sif_wbridge #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int REG_DEPTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input logic           clk,
  input logic           rst,
  sif_wbridge_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic [DATA_W-1:0] regs   [REG_DEPTH];
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [DATA_W-1:0] data_rd;
  logic              rd_vld;
  logic              err;
  logic [CNT_W-1:0]  drops;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign in_range = bus.xa_addr < ADDR_W'(REG_DEPTH);
  assign idx      = bus.xa_addr[IDX_W-1:0];
  // Full/empty come from the occupancy count so pointer equality is never ambiguous.
  assign full     = count == LVL_W'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign push     = bus.xa_wr_s && in_range && !full;
  assign pop      = !empty && bus.wa_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else if (push) begin
      regs[idx] <= bus.xa_data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.xa_addr;
      q_data[wr_ptr] <= bus.xa_data_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rd <= '0;
      rd_vld  <= 1'b0;
      err     <= 1'b0;
      drops   <= '0;
    end else begin
      rd_vld <= bus.xa_rd_s;
      if (bus.xa_rd_s) data_rd <= in_range ? regs[idx] : '0;
      err <= (bus.xa_wr_s && (!in_range || full)) || (bus.xa_rd_s && !in_range);
      if (bus.xa_wr_s && in_range && full && (drops != '1)) drops <= drops + CNT_W'(1);
    end
  end

  assign bus.xa_data_rd = data_rd;
  assign bus.xa_rd_vld  = rd_vld;
  assign bus.xa_err     = err;
  assign bus.xa_busy    = full;
  assign bus.wa_wr_s    = !empty;
  assign bus.wa_addr    = empty ? '0 : q_addr[rd_ptr];
  assign bus.wa_data_wr = empty ? '0 : q_data[rd_ptr];
  assign bus.wa_level   = count;
  assign bus.drop_cnt   = drops;
endmodule

// File: tb/tb_sif_wbridge.sv
`timescale 1ns/1ps
// Directed bench for sif_wbridge: a register model and two scoreboard queues
// (read data, W-side beats) checked by a negedge monitor.
module tb_sif_wbridge;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [15:0] r_q [$];
  logic [31:0] w_q [$];
  logic [15:0] model [16];
  logic [7:0]  exp_drop;
  logic        exp_err;

  sif_wbridge_if #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4), .CNT_W(8)) bus ();

  sif_wbridge #(
    .ADDR_W(16), .DATA_W(16), .REG_DEPTH(16), .FIFO_DEPTH(4), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drives one X-side access for one clock, recording what the DUT must produce.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                               input logic [15:0] data);
    logic inr;
    logic full;
    inr  = addr < 16'd16;
    full = (w_q.size() == 4);
    bus.xa_wr_s    = wr;
    bus.xa_rd_s    = rd;
    bus.xa_addr    = addr;
    bus.xa_data_wr = data;
    if (rd) r_q.push_back(inr ? model[addr[3:0]] : 16'h0000);
    if (wr && inr && !full) begin
      model[addr[3:0]] = data;
      w_q.push_back({addr, data});
    end
    if (wr && inr && full && exp_drop != 8'hFF) exp_drop++;
    exp_err = (wr && (!inr || full)) || (rd && !inr);
    @(posedge clk);
    #1;
    bus.xa_wr_s = 1'b0;
    bus.xa_rd_s = 1'b0;
    checkOutput("xa_err", {31'b0, bus.xa_err}, {31'b0, exp_err});
    checkOutput("drop_cnt", {24'b0, bus.drop_cnt}, {24'b0, exp_drop});
  endtask

  task automatic drainW();
    bus.wa_rdy = 1'b1;
    for (int k = 0; k < 20 && w_q.size() != 0; k++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("w_drained", 32'(w_q.size()), 32'd0);
    checkOutput("wa_level_empty", {28'b0, bus.wa_level}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.xa_rd_vld) begin
        checkOutput("rd_expected", {31'b0, r_q.size() != 0}, 32'd1);
        if (r_q.size() != 0) checkOutput("xa_data_rd", {16'b0, bus.xa_data_rd}, {16'b0, r_q.pop_front()});
      end
      if (bus.wa_wr_s && bus.wa_rdy) begin
        checkOutput("w_expected", {31'b0, w_q.size() != 0}, 32'd1);
        if (w_q.size() != 0) checkOutput("w_beat", {bus.wa_addr, bus.wa_data_wr}, w_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.xa_addr = '0;
    bus.xa_data_wr = '0;
    bus.xa_wr_s = 1'b0;
    bus.xa_rd_s = 1'b0;
    bus.wa_rdy = 1'b0;
    exp_drop = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1;
    checkOutput("rst_rd_vld", {31'b0, bus.xa_rd_vld}, 32'd0);
    checkOutput("rst_err", {31'b0, bus.xa_err}, 32'd0);
    checkOutput("rst_data_rd", {16'b0, bus.xa_data_rd}, 32'd0);
    checkOutput("rst_wa_wr_s", {31'b0, bus.wa_wr_s}, 32'd0);
    checkOutput("rst_wa_bus", {bus.wa_addr, bus.wa_data_wr}, 32'd0);
    checkOutput("rst_level", {28'b0, bus.wa_level}, 32'd0);
    checkOutput("rst_drop", {24'b0, bus.drop_cnt}, 32'd0);
    checkOutput("rst_busy", {31'b0, bus.xa_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(1'b0, 1'b1, 16'd3, 16'h0);

    bus.wa_rdy = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd2, 16'h00A5);
    checkOutput("wr_wa_wr_s", {31'b0, bus.wa_wr_s}, 32'd1);
    checkOutput("wr_level", {28'b0, bus.wa_level}, 32'd1);
    checkOutput("wr_head", {bus.wa_addr, bus.wa_data_wr}, 32'h0002_00A5);
    applyStimulus(1'b0, 1'b1, 16'd2, 16'h0);
    checkOutput("pop_level", {28'b0, bus.wa_level}, 32'd0);
    checkOutput("pop_wa_wr_s", {31'b0, bus.wa_wr_s}, 32'd0);

    // Fill with W stalled; the fifth write must be refused and counted.
    bus.wa_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i), 16'h0010 + 16'(i));
      if (i == 2) checkOutput("busy_at3", {31'b0, bus.xa_busy}, 32'd0);
      if (i == 3) checkOutput("busy_at4", {31'b0, bus.xa_busy}, 32'd1);
    end
    checkOutput("full_level", {28'b0, bus.wa_level}, 32'd4);
    checkOutput("stall_head", {bus.wa_addr, bus.wa_data_wr}, 32'h0000_0010);
    applyStimulus(1'b0, 1'b1, 16'd4, 16'h0);
    drainW();

    applyStimulus(1'b1, 1'b0, 16'd20, 16'hBEEF);
    checkOutput("oor_wa_wr_s", {31'b0, bus.wa_wr_s}, 32'd0);
    checkOutput("oor_level", {28'b0, bus.wa_level}, 32'd0);

    applyStimulus(1'b1, 1'b0, 16'd5, 16'h2222);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'd5, 16'h1111);
    applyStimulus(1'b0, 1'b1, 16'd5, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'd20, 16'h3333);
    applyStimulus(1'b0, 1'b1, 16'd17, 16'h0);
    drainW();

    // A pop in the same cycle does not let a write into a full FIFO.
    bus.wa_rdy = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'd8 + 16'(i), 16'h0A00 + 16'(i));
    bus.wa_rdy = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd12, 16'h0C0C);
    checkOutput("full_pop_level", {28'b0, bus.wa_level}, 32'd3);
    drainW();
    applyStimulus(1'b0, 1'b1, 16'd12, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'd9, 16'h0);

    bus.wa_rdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'd6, 16'h0666);
    applyStimulus(1'b1, 1'b0, 16'd7, 16'h0777);
    applyStimulus(1'b1, 1'b0, 16'd8, 16'h0888);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_wa_wr_s", {31'b0, bus.wa_wr_s}, 32'd0);
    checkOutput("mid_rst_level", {28'b0, bus.wa_level}, 32'd0);
    checkOutput("mid_rst_drop", {24'b0, bus.drop_cnt}, 32'd0);
    checkOutput("mid_rst_busy", {31'b0, bus.xa_busy}, 32'd0);
    w_q.delete();
    r_q.delete();
    for (int i = 0; i < 16; i++) model[i] = '0;
    exp_drop = '0;
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'd2, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'd5, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'd6, 16'h0);
    drainW();
    applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
    checkOutput("rd_q_empty", 32'(r_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
